// File: rtl/afifo_pkg.sv
// Shared definitions for the async FIFO front ends.
package afifo_pkg;

    // Default pointer width and the FIFO depth it implies (address is one bit narrower).
    localparam int WIDTH_DEF = 4;
    localparam int DEPTH     = 1 << (WIDTH_DEF - 1);

    // Gray to binary: bit i is the XOR of all Gray bits at and above i.
    // Zero-extended upper bits do not disturb the prefix XOR, so any width up to 32 works.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = '0;
        for (int i = 0; i < 32; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/afifo_wr_front_if.sv
// Producer-side valid/ready handshake into the write front end.
interface afifo_wr_front_if #(
    parameter int DW = 8
);
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/sync_2ff.sv
// Plain two-flop synchroniser for Gray-coded pointers crossing clock domains.
module sync_2ff #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_d, meta_q;
    logic [W-1:0] sync_d, sync_q;

    // First stage samples the foreign-domain bus directly; second stage settles it.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchroniser chain registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/afifo_wr_front.sv
// Write-domain front end: 2-entry skid buffer feeding the FIFO, read-pointer
// synchroniser, and occupancy / almost-full reporting.
module afifo_wr_front
    import afifo_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DW    = 8
) (
    input  logic               wclk,
    input  logic               wrst_n,
    afifo_wr_front_if.slave    s_if,
    input  logic [WIDTH-1:0]   rptr,
    output logic [WIDTH-1:0]   wq2_rptr,
    input  logic [WIDTH-1:0]   wptr,
    input  logic               wfull,
    output logic               winc,
    output logic [DW-1:0]      wdata,
    input  logic [WIDTH-1:0]   afull_thresh,
    output logic [WIDTH-1:0]   wlevel,
    output logic               walmost_full
);

    localparam int DEPTH_W = 1 << (WIDTH - 1);

    logic          main_valid_d, main_valid_q;
    logic          skid_valid_d, skid_valid_q;
    logic [DW-1:0] main_data_d,  main_data_q;
    logic [DW-1:0] skid_data_d,  skid_data_q;
    logic          s_ready_d,    s_ready_q;
    logic          walmost_full_d, walmost_full_q;
    logic          accept, drain;
    logic [WIDTH-1:0] wbin, rbin;

    sync_2ff #(.W(WIDTH)) u_rptr_sync (
        .clk   (wclk),
        .rst_n (wrst_n),
        .d     (rptr),
        .q     (wq2_rptr)
    );

    // Occupancy from the write side; stale read pointer makes it pessimistic.
    always_comb begin
        wbin           = WIDTH'(gray2bin(32'(wptr)));
        rbin           = WIDTH'(gray2bin(32'(wq2_rptr)));
        wlevel         = wbin - rbin;
        walmost_full_d = (wlevel >= afull_thresh);
    end

    // Skid stage next state: main drains into the FIFO, skid catches the one
    // word that may arrive while main is stalled and s_ready is still high.
    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;
        accept       = s_if.s_valid & s_ready_q;
        drain        = main_valid_q & ~wfull;
        if (drain || !main_valid_q) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
            end else begin
                main_valid_d = accept;
                if (accept) main_data_d = s_if.s_data;
            end
            skid_valid_d = 1'b0;
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = s_if.s_data;
        end
        s_ready_d = ~skid_valid_d;
    end

    // Skid stage and flag registers.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            main_valid_q   <= 1'b0;
            skid_valid_q   <= 1'b0;
            main_data_q    <= '0;
            skid_data_q    <= '0;
            s_ready_q      <= 1'b1;
            walmost_full_q <= 1'b0;
        end else begin
            main_valid_q   <= main_valid_d;
            skid_valid_q   <= skid_valid_d;
            main_data_q    <= main_data_d;
            skid_data_q    <= skid_data_d;
            s_ready_q      <= s_ready_d;
            walmost_full_q <= walmost_full_d;
        end
    end

    assign winc         = drain;
    assign wdata        = main_data_q;
    assign s_if.s_ready = s_ready_q;
    assign walmost_full = walmost_full_q;

    // Skid may only hold data while main also holds data.
    a_no_skid_only: assert property (@(posedge wclk) disable iff (!wrst_n)
        !(skid_valid_q && !main_valid_q));

    // Occupancy can never exceed the FIFO depth.
    a_level_bound: assert property (@(posedge wclk) disable iff (!wrst_n)
        int'(wlevel) <= DEPTH_W);

    // Write strobe must never hit a full FIFO.
    a_no_write_full: assert property (@(posedge wclk) disable iff (!wrst_n)
        !(winc && wfull));

endmodule
